// File: rtl/pad_bus_seq_if.sv
// Core-side request/response signals plus the IOBUF wrapper pins driven by pad_bus_seq.
// The slave modport is the sequencer; the master modport is the requester and pad-wrapper side.
interface pad_bus_seq_if #(
    parameter int WIDTH = 8
);
    logic             wr_req;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             ack;
    logic             busy;
    logic [WIDTH-1:0] pad_din;
    logic             pad_oen_n;
    logic [WIDTH-1:0] pad_dout;

    modport master (
        output wr_req, wr_data, rd_req, pad_dout,
        input  rd_data, ack, busy, pad_din, pad_oen_n
    );

    modport slave (
        input  wr_req, wr_data, rd_req, pad_dout,
        output rd_data, ack, busy, pad_din, pad_oen_n
    );
endinterface

// File: rtl/pad_bus_seq.sv
// Half-duplex pad bus sequencer with programmable turnaround around each write drive window.
// Optional macro PAD_SYNC_EN adds a 2-flop synchroniser on pad_dout and two extra read states.
module pad_bus_seq #(
    parameter int WIDTH       = 8,
    parameter int TA_CYCLES   = 2,
    parameter int HOLD_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    pad_bus_seq_if.slave bus
);
    localparam logic [7:0] TA_LOAD   = 8'(TA_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

`ifdef PAD_SYNC_EN
    typedef enum logic [2:0] {
        IDLE, TA_IN, DRIVE, RELEASE, SAMPLE, ACK, SYNC1, SYNC2
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, TA_IN, DRIVE, RELEASE, SAMPLE, ACK
    } state_t;
`endif

    state_t           state;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] sample_src;

`ifdef PAD_SYNC_EN
    // Free-running synchroniser; it has no reset so it always tracks the pads.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        sync1_q <= bus.pad_dout;
        sync2_q <= sync1_q;
    end

    assign sample_src = sync2_q;
`else
    assign sample_src = bus.pad_dout;
`endif

    // Each timed state loads cnt with N-1 on entry and leaves when it reaches 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.pad_oen_n <= 1'b1;
            bus.pad_din   <= '0;
            bus.rd_data   <= '0;
            bus.ack       <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.wr_req) begin
                        bus.pad_din <= bus.wr_data;
                        bus.busy    <= 1'b1;
                        cnt         <= TA_LOAD;
                        state       <= TA_IN;
                    end else if (bus.rd_req) begin
                        bus.busy <= 1'b1;
`ifdef PAD_SYNC_EN
                        state    <= SYNC1;
`else
                        state    <= SAMPLE;
`endif
                    end
                end
                TA_IN: begin
                    if (cnt == 8'd0) begin
                        bus.pad_oen_n <= 1'b0;
                        cnt           <= HOLD_LOAD;
                        state         <= DRIVE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DRIVE: begin
                    if (cnt == 8'd0) begin
                        bus.pad_oen_n <= 1'b1;
                        cnt           <= TA_LOAD;
                        state         <= RELEASE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RELEASE: begin
                    if (cnt == 8'd0) begin
                        bus.ack <= 1'b1;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef PAD_SYNC_EN
                SYNC1: state <= SYNC2;
                SYNC2: state <= SAMPLE;
`endif
                SAMPLE: begin
                    bus.rd_data <= sample_src;
                    bus.ack     <= 1'b1;
                    state       <= ACK;
                end
                ACK: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.pad_oen_n <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pad_bus_seq.sv
// Directed self-checking bench for pad_bus_seq with a simple external pad device model.
`timescale 1ns/1ps
module tb_pad_bus_seq;
    localparam int WIDTH  = 8;
    localparam int TA     = 2;
    localparam int HOLD   = 4;
    localparam int WR_LAT = 2 * TA + HOLD;
`ifdef PAD_SYNC_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    pad_bus_seq_if #(.WIDTH(WIDTH)) bus ();

    pad_bus_seq #(
        .WIDTH      (WIDTH),
        .TA_CYCLES  (TA),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // External device drives only once the pads have been released for two cycles.
    logic             ext_want = 1'b0;
    logic [WIDTH-1:0] ext_val  = '0;
    logic             oen_q    = 1'b0;
    logic             dut_drive;
    logic             ext_drive;
    logic [WIDTH-1:0] io_pad;

    always @(posedge clk) oen_q <= bus.pad_oen_n;

    always_comb begin
        dut_drive = (bus.pad_oen_n !== 1'b1);
        ext_drive = ext_want && (bus.pad_oen_n === 1'b1) && (oen_q === 1'b1);
        if (dut_drive && ext_drive)
            io_pad = 'x;
        else if (dut_drive)
            io_pad = bus.pad_din;
        else if (ext_drive)
            io_pad = ext_val;
        else
            io_pad = 'z;
    end

    assign bus.pad_dout = io_pad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int kk;
        rst         = 1'b1;
        bus.wr_req  = 1'b1;
        bus.wr_data = 8'hFF;
        bus.rd_req  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.pad_oen_n !== 1'b1 || bus.ack !== 1'b0 || bus.busy !== 1'b0 ||
                bus.pad_din !== 8'h00 || bus.rd_data !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL reset_state cyc%0d: oen_n=%b ack=%b busy=%b din=%h rd=%h, want 1 0 0 00 00",
                         i, bus.pad_oen_n, bus.ack, bus.busy, bus.pad_din, bus.rd_data);
            end
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.busy !== 1'b1 || bus.pad_din !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_accept: busy=%b din=%h, want 1 ff", bus.busy, bus.pad_din);
        end
        kk = 0;
        while (bus.ack !== 1'b1 && kk < 20) begin
            tick();
            kk++;
        end
        tests_run++;
        if (kk !== WR_LAT) begin
            tests_failed++;
            $display("[TB] FAIL reset_write_latency: ack after %0d, want %0d", kk, WR_LAT);
        end
        bus.wr_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write();
        logic exp_oen, exp_ack, exp_busy;
        ext_want    = 1'b1;
        ext_val     = 8'hC3;
        bus.wr_data = 8'hA5;
        bus.wr_req  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_oen  = !(k >= TA && k < TA + HOLD);
            exp_ack  = (k == WR_LAT);
            exp_busy = (k <= WR_LAT);
            tests_run++;
            if (bus.pad_oen_n !== exp_oen || bus.ack !== exp_ack || bus.busy !== exp_busy ||
                bus.pad_din !== 8'hA5) begin
                tests_failed++;
                $display("[TB] FAIL write_k%0d: oen_n=%b ack=%b busy=%b din=%h, want %b %b %b a5",
                         k, bus.pad_oen_n, bus.ack, bus.busy, bus.pad_din, exp_oen, exp_ack, exp_busy);
            end
            if (!exp_oen) begin
                tests_run++;
                if (io_pad !== 8'hA5) begin
                    tests_failed++;
                    $display("[TB] FAIL write_io_pad_k%0d: io_pad=%h, want a5", k, io_pad);
                end
            end
            if (bus.ack === 1'b1) bus.wr_req = 1'b0;
        end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_read();
        logic exp_ack, exp_busy;
        ext_want   = 1'b1;
        ext_val    = 8'h3C;
        bus.rd_req = 1'b1;
        for (int k = 0; k < RD_LAT + 4; k++) begin
            tick();
            exp_ack  = (k == RD_LAT);
            exp_busy = (k <= RD_LAT);
            tests_run++;
            if (bus.pad_oen_n !== 1'b1 || bus.ack !== exp_ack || bus.busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL read_k%0d: oen_n=%b ack=%b busy=%b, want 1 %b %b",
                         k, bus.pad_oen_n, bus.ack, bus.busy, exp_ack, exp_busy);
            end
            if (k == RD_LAT) begin
                tests_run++;
                if (bus.rd_data !== 8'h3C) begin
                    tests_failed++;
                    $display("[TB] FAIL read_data: rd_data=%h, want 3c", bus.rd_data);
                end
            end
            if (bus.ack === 1'b1) bus.rd_req = 1'b0;
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_both();
        int acks;
        acks        = 0;
        ext_val     = 8'h81;
        bus.wr_data = 8'h5A;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        for (int k = 0; k < WR_LAT + 2 + RD_LAT + 5; k++) begin
            tick();
            if (bus.ack === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    tests_run++;
                    if (k !== WR_LAT || bus.pad_din !== 8'h5A || bus.rd_data !== 8'h3C) begin
                        tests_failed++;
                        $display("[TB] FAIL both_ack1: k=%0d din=%h rd=%h, want %0d 5a 3c",
                                 k, bus.pad_din, bus.rd_data, WR_LAT);
                    end
                    bus.wr_req = 1'b0;
                end else if (acks == 2) begin
                    tests_run++;
                    if (k !== WR_LAT + 2 + RD_LAT || bus.rd_data !== 8'h81) begin
                        tests_failed++;
                        $display("[TB] FAIL both_ack2: k=%0d rd=%h, want %0d 81",
                                 k, bus.rd_data, WR_LAT + 2 + RD_LAT);
                    end
                    bus.rd_req = 1'b0;
                end
            end
        end
        tests_run++;
        if (acks !== 2) begin
            tests_failed++;
            $display("[TB] FAIL both_ack_count: %0d acks, want 2", acks);
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int kk;
        bus.wr_data = 8'h77;
        bus.wr_req  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        tests_run++;
        if (bus.pad_oen_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_in_drive: oen_n=%b, want 0", bus.pad_oen_n);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (bus.pad_oen_n !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 1'b0 || bus.pad_din !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: oen_n=%b busy=%b ack=%b din=%h, want 1 0 0 00",
                     bus.pad_oen_n, bus.busy, bus.ack, bus.pad_din);
        end
        rst        = 1'b0;
        bus.wr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.pad_oen_n !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL mid_quiet_k%0d: ack=%b busy=%b oen_n=%b, want 0 0 1",
                         k, bus.ack, bus.busy, bus.pad_oen_n);
            end
        end
        ext_val    = 8'hE7;
        bus.rd_req = 1'b1;
        tick();
        kk = 0;
        while (bus.ack !== 1'b1 && kk < 12) begin
            tick();
            kk++;
        end
        tests_run++;
        if (kk !== RD_LAT || bus.rd_data !== 8'hE7) begin
            tests_failed++;
            $display("[TB] FAIL mid_idle_read: ack after %0d rd=%h, want %0d e7", kk, bus.rd_data, RD_LAT);
        end
        bus.rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic             is_wr;
        logic [WIDTH-1:0] cur;
        int               kk, drive_cnt, bad_drive, clash;
        ext_want = 1'b1;
        is_wr    = 1'($urandom_range(0, 1));
        cur      = WIDTH'($urandom);
        if (is_wr) begin bus.wr_data = cur; bus.wr_req = 1'b1; bus.rd_req = 1'b0; end
        else       begin ext_val = cur;     bus.rd_req = 1'b1; bus.wr_req = 1'b0; end
        for (int t = 0; t < 100; t++) begin
            kk = 0; drive_cnt = 0; bad_drive = 0; clash = 0;
            do begin
                tick();
                kk++;
                if ((dut_drive && ext_drive) || (dut_drive && $isunknown(io_pad))) clash++;
                if (bus.pad_oen_n === 1'b0) begin
                    drive_cnt++;
                    if (io_pad !== cur) bad_drive++;
                end
            end while (bus.ack !== 1'b1 && kk < 40);
            tests_run++;
            if (bus.ack !== 1'b1 || clash != 0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d_done: ack=%b clash=%0d, want 1 0", t, bus.ack, clash);
            end
            tests_run++;
            if (is_wr && (drive_cnt != HOLD || bad_drive != 0)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d_write: drives=%0d bad=%0d, want %0d 0 (data %h)",
                         t, drive_cnt, bad_drive, HOLD, cur);
            end else if (!is_wr && (drive_cnt != 0 || bus.rd_data !== cur)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d_read: drives=%0d rd=%h, want 0 %h", t, drive_cnt, bus.rd_data, cur);
            end
            if (t == 99) begin
                bus.wr_req = 1'b0;
                bus.rd_req = 1'b0;
            end else begin
                is_wr = 1'($urandom_range(0, 1));
                cur   = WIDTH'($urandom);
                if (is_wr) begin bus.wr_data = cur; bus.wr_req = 1'b1; bus.rd_req = 1'b0; end
                else       begin ext_val = cur;     bus.rd_req = 1'b1; bus.wr_req = 1'b0; end
            end
        end
        tick();
        tick();
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.wr_data = '0;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pad_bus_seq.md
Name: pad_bus_seq

Overview:
- Sequencer for a bank of bidirectional tri-state pads built from the team's IOBUF wrapper (din / oen_N / io_pad / dout).
- Serialises write and read transactions from one core-side requester onto a shared half-duplex pad bus.
- Inserts programmable turnaround so the pads and the external device never drive at the same time.
- Sits between a bus-slave register block (e.g. AHB GPIO/parallel-port slave in the Cortex-M3 example SoC) and the pad wrapper.

Parameters:
WIDTH, 8, pad bus width in bits
TA_CYCLES, 2, turnaround cycles before and after each drive window (legal range 1..255)
HOLD_CYCLES, 4, cycles the pads are actively driven per write (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
wr_req  input  1  write request, level; sampled only in IDLE
wr_data  input  WIDTH  write data, captured on write accept
rd_req  input  1  read request, level; sampled only in IDLE
rd_data  output  WIDTH  last read value, updated on read completion
ack  output  1  one-cycle completion pulse for the current transaction
busy  output  1  high from the accept edge until the cycle after ack
pad_din  output  WIDTH  to wrapper din (core-to-pad data)
pad_oen_n  output  1  to wrapper oen_N (1 = tristate/input, 0 = drive)
pad_dout  input  WIDTH  from wrapper dout (pad-to-core data)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: pad_oen_n=1, pad_din=0, rd_data=0, ack=0, busy=0, state IDLE, counter 0.
- States: IDLE, TA_IN, DRIVE, RELEASE, SAMPLE, ACK. PAD_SYNC_EN adds SYNC1 and SYNC2.
- IDLE:
  - pads are in input mode;
  - wr_req=1 -> pad_din<=wr_data, go to TA_IN, busy<=1;
  - otherwise rd_req=1 -> go to SAMPLE (or SYNC1), busy<=1;
  - both high -> write wins; the read is served on a later IDLE if rd_req is still high.
- TA_IN: TA_CYCLES cycles, pad_oen_n=1, then DRIVE.
- DRIVE: HOLD_CYCLES cycles, pad_oen_n=0, then RELEASE.
  - pad_oen_n is 0 in exactly the DRIVE cycles, never otherwise.
  - pad_din is stable for the whole window.
- RELEASE: TA_CYCLES cycles, pad_oen_n=1, then ACK.
- SAMPLE: 1 cycle; rd_data<=pad_dout at its closing edge, then ACK.
- ACK: 1 cycle, ack=1, then IDLE. busy deasserts on the edge leaving ACK.
- Write latency: with the accept edge as E0, pad_oen_n falls after E0+TA_CYCLES, rises after E0+TA_CYCLES+HOLD_CYCLES, and ack is high in the cycle after E0+2*TA_CYCLES+HOLD_CYCLES.
- Read latency: ack is high in the cycle after E0+1 (no PAD_SYNC_EN).
- Requester rules:
  - hold req until ack, then drop it;
  - a req still high in IDLE starts a new transaction (back-to-back allowed, minimum 1 IDLE cycle between);
  - requests and data changes outside IDLE are ignored.
- pad_din retains the last written value after a write; no return to 0.
- Turnaround counter: 8-bit down-counter loaded with N-1 on state entry; exits at 0.
- Reset mid-transaction: next edge forces pad_oen_n=1 and IDLE; no ack is issued for the aborted transaction; pad_din=0.

Optional Feature:
- Macro: PAD_SYNC_EN.
- Defined:
  - pad_dout passes through a 2-flop synchroniser, free-running every cycle;
  - reads go IDLE -> SYNC1 -> SYNC2 -> SAMPLE -> ACK;
  - SAMPLE captures the second sync flop;
  - read ack is high in the cycle after E0+3.
- Not defined: no synchroniser; SAMPLE captures pad_dout directly; read ack is high after E0+1.
- Write timing is identical in both builds.

Test Plan:
- Bench config for all scenarios: WIDTH=8, TA_CYCLES=2, HOLD_CYCLES=4.
1. Reset: assert rst for 3 cycles with wr_req=1 -> pad_oen_n=1, ack=0, busy=0, pad_din=0x00, rd_data=0x00 throughout; after release a write is accepted on the first IDLE edge.
2. Write 0xA5 accepted at E0:
   - pad_oen_n=0 for exactly 4 cycles, after E0+2 through E0+6;
   - io_pad=0xA5 in that window, pad_din held at 0xA5 afterwards;
   - single ack pulse after E0+8; busy high E0 through ack.
3. Read with the external model driving 0x3C on io_pad:
   - rd_data=0x3C with ack after E0+1, or after E0+3 with PAD_SYNC_EN;
   - pad_oen_n stays 1 throughout.
4. wr_req=1 (0x5A) and rd_req=1 in the same cycle:
   - write completes first (ack #1);
   - read then completes (ack #2) with rd_data = external value 0x81;
   - exactly two ack pulses.
5. rst asserted in the 2nd DRIVE cycle of a write -> pad_oen_n=1 on the next edge, no ack, state IDLE, busy=0.
6. Contention check:
   - the external model drives io_pad only while pad_oen_n has been 1 for 2 or more cycles;
   - run 100 random back-to-back read/write requests;
   - no X/contention on io_pad, and every write value is observed on io_pad during its drive window.
